// File: rtl/pipe_hazard.sv
// Hazard unit for an in-order pipeline: tracks post-ID destinations, picks forwarding
// sources per operand, raises load-use stalls and branch flushes, and counts both events.

module pipe_hazard_src #(
  parameter int DW     = 16,
  parameter int RW     = 4,
  parameter int DEPTH  = 3,
  parameter int LD_LAT = 1,
  parameter int SW     = $clog2(DEPTH+1)
) (
  input  logic [RW-1:0]                src_i,
  input  logic                         used_i,
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [DEPTH-1:0]             we_i,
  input  logic [DEPTH-1:0]             ld_i,
  input  logic [DEPTH-1:0][RW-1:0]     rd_i,
  input  logic [DEPTH*DW-1:0]          res_data_i,
  input  logic [DW-1:0]                rf_data_i,
  output logic [SW-1:0]                sel_o,
  output logic [DW-1:0]                data_o,
  output logic                         pend_o
);
  logic [DEPTH-1:0] hit;

  for (genvar k = 0; k < DEPTH; k++) begin : g_hit
    assign hit[k] = vld_i[k] & we_i[k] & used_i & (|src_i) & (rd_i[k] == src_i);
  end

  // Walk oldest to youngest so the youngest (lowest index) hit is written last and wins.
  always_comb begin
    sel_o  = '0;
    data_o = rf_data_i;
    pend_o = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (hit[k]) begin
        sel_o  = SW'(k+1);
        data_o = res_data_i[k*DW +: DW];
        pend_o = ld_i[k] && (k < LD_LAT);
      end
    end
  end
endmodule

module pipe_hazard #(
  parameter int DW     = 16,
  parameter int RW     = 4,
  parameter int DEPTH  = 3,
  parameter int LD_LAT = 1,
  parameter int SW     = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [RW-1:0]       id_rs,
  input  logic [RW-1:0]       id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [RW-1:0]       id_rd,
  input  logic                id_we,
  input  logic                id_ld,
  input  logic                br_taken,
  input  logic [DEPTH*DW-1:0] res_data,
  input  logic [DW-1:0]       rf_rs_data,
  input  logic [DW-1:0]       rf_rt_data,
  output logic                stall,
  output logic                flush,
  output logic [SW-1:0]       fwd_rs_sel,
  output logic [SW-1:0]       fwd_rt_sel,
  output logic [DW-1:0]       fwd_rs_data,
  output logic [DW-1:0]       fwd_rt_data,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         flush_cnt
);
  localparam int NSRC = 2;

  logic [DEPTH-1:0]          vld_q, we_q, ld_q;
  logic [DEPTH-1:0][RW-1:0]  rd_q;
  logic [15:0]               stall_cnt_q, stall_cnt_d;
  logic [15:0]               flush_cnt_q, flush_cnt_d;

  logic [NSRC-1:0][RW-1:0]   src_addr;
  logic [NSRC-1:0]           src_used;
  logic [NSRC-1:0][DW-1:0]   src_rf;
  logic [NSRC-1:0][SW-1:0]   src_sel;
  logic [NSRC-1:0][DW-1:0]   src_data;
  logic [NSRC-1:0]           src_pend;

  assign src_addr = {id_rt, id_rs};
  assign src_used = {id_rt_used, id_rs_used};
  assign src_rf   = {rf_rt_data, rf_rs_data};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    pipe_hazard_src #(
      .DW(DW), .RW(RW), .DEPTH(DEPTH), .LD_LAT(LD_LAT), .SW(SW)
    ) u_src (
      .src_i      (src_addr[s]),
      .used_i     (src_used[s]),
      .vld_i      (vld_q),
      .we_i       (we_q),
      .ld_i       (ld_q),
      .rd_i       (rd_q),
      .res_data_i (res_data),
      .rf_data_i  (src_rf[s]),
      .sel_o      (src_sel[s]),
      .data_o     (src_data[s]),
      .pend_o     (src_pend[s])
    );
  end

  // A taken branch kills the ID instruction, so it can never also stall.
  assign flush       = br_taken;
  assign stall       = id_valid & ~br_taken & (|src_pend);
  assign fwd_rs_sel  = src_sel[0];
  assign fwd_rt_sel  = src_sel[1];
  assign fwd_rs_data = src_data[0];
  assign fwd_rt_data = src_data[1];

  assign stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  assign flush_cnt_d = (flush && (flush_cnt_q != 16'hFFFF)) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  // Only the valid bit is gated on a bubble; rd/we/ld are don't-care when invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q       <= '0;
      we_q        <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        we_q[k]  <= we_q[k-1];
        ld_q[k]  <= ld_q[k-1];
        rd_q[k]  <= rd_q[k-1];
      end
      vld_q[0]    <= id_valid & ~stall & ~flush;
      we_q[0]     <= id_we;
      ld_q[0]     <= id_ld;
      rd_q[0]     <= id_rd;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard.sv
// Bench for pipe_hazard: a queue-style model of in-flight writers checked every cycle,
// plus directed load-use, priority, flush, r0, reset and saturation scenarios.

module tb_pipe_hazard;
  localparam int DW = 16, RW = 4, DEPTH = 3, LD_LAT = 1, SW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid, id_rs_used, id_rt_used, id_we, id_ld, br_taken;
  logic [RW-1:0]       id_rs, id_rt, id_rd;
  logic [DEPTH*DW-1:0] res_data;
  logic [DW-1:0]       rf_rs_data, rf_rt_data;
  logic                stall, flush;
  logic [SW-1:0]       fwd_rs_sel, fwd_rt_sel;
  logic [DW-1:0]       fwd_rs_data, fwd_rt_data;
  logic [15:0]         stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard #(.DW(DW), .RW(RW), .DEPTH(DEPTH), .LD_LAT(LD_LAT), .SW(SW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_ld(id_ld), .br_taken(br_taken), .res_data(res_data), .rf_rs_data(rf_rs_data),
    .rf_rt_data(rf_rt_data), .stall(stall), .flush(flush), .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel), .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct packed { logic vld; logic [RW-1:0] rd; logic we; logic ld; } ent_t;
  typedef struct packed { logic [31:0] sel; logic [DW-1:0] data; logic pend; } res_t;

  ent_t [DEPTH-1:0] m_ent;
  int               m_scnt, m_fcnt;
  res_t             e_rs, e_rt;
  logic             e_stall, e_flush;

  // Youngest in-flight writer of the register wins; r0 and unused sources go to the RF.
  function automatic res_t resolve(input ent_t [DEPTH-1:0] ents, input logic [RW-1:0] src,
                                   input logic used, input logic [DW-1:0] rf,
                                   input logic [DEPTH*DW-1:0] res);
    res_t r;
    r.sel = 0; r.data = rf; r.pend = 1'b0;
    if (used && src != 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ents[k].vld && ents[k].we && ents[k].rd == src) begin
          r.sel  = 32'(k + 1);
          r.data = res[k*DW +: DW];
          r.pend = ents[k].ld && (k < LD_LAT);
          break;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    e_rs    = resolve(m_ent, id_rs, id_rs_used, rf_rs_data, res_data);
    e_rt    = resolve(m_ent, id_rt, id_rt_used, rf_rt_data, res_data);
    e_flush = br_taken;
    e_stall = id_valid && !br_taken && (e_rs.pend || e_rt.pend);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ent  <= '0;
      m_scnt <= 0;
      m_fcnt <= 0;
    end else begin
      m_ent  <= {m_ent[DEPTH-2:0],
                 ent_t'{vld: id_valid && !e_stall && !e_flush, rd: id_rd, we: id_we, ld: id_ld}};
      if (e_stall && m_scnt < 65535) m_scnt <= m_scnt + 1;
      if (e_flush && m_fcnt < 65535) m_fcnt <= m_fcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("rs_sel", 32'(fwd_rs_sel), e_rs.sel);
    chk("rt_sel", 32'(fwd_rt_sel), e_rt.sel);
    chk("rs_data", 32'(fwd_rs_data), 32'(e_rs.data));
    chk("rt_data", 32'(fwd_rt_data), 32'(e_rt.data));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
  end

  // ---------------- stimulus ----------------
  task automatic idset(input logic v, input logic [RW-1:0] rd, input logic we, input logic ld,
                       input logic [RW-1:0] rs, input logic rsu,
                       input logic [RW-1:0] rt, input logic rtu);
    id_valid = v; id_rd = rd; id_we = we; id_ld = ld;
    id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; br_taken = 1'b0;
    rf_rs_data = 16'hF00D; rf_rt_data = 16'hBEEF;
    res_data = {16'h3333, 16'h2222, 16'h1111};
    idset(1, 4'd3, 1, 1, 4'd3, 1, 4'd3, 1);
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rs_sel", 32'(fwd_rs_sel), 32'd0);
    chk("rst_rs_data", 32'(fwd_rs_data), 32'hF00D);
    chk("rst_rt_data", 32'(fwd_rt_data), 32'hBEEF);
    chk("rst_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
    step();
    rst = 1'b1;

    // Forward from EX
    idset(1, 4'd3, 1, 0, 4'd1, 0, 4'd2, 0);
    step();
    idset(1, 4'd4, 1, 0, 4'd3, 1, 4'd2, 0);
    res_data[0 +: DW] = 16'h1234;
    #2;
    chk("fwd_ex_sel", 32'(fwd_rs_sel), 32'd1);
    chk("fwd_ex_data", 32'(fwd_rs_data), 32'h1234);
    chk("fwd_ex_stall", 32'(stall), 32'd0);
    chk("model_fwd_ex_sel", e_rs.sel, 32'd1);
    step();

    // Load-use: one stall cycle, then forward from entry 1
    idset(1, 4'd5, 1, 1, 4'd0, 0, 4'd0, 0);
    step();
    idset(1, 4'd6, 1, 0, 4'd0, 0, 4'd5, 1);
    res_data[DW +: DW] = 16'h5555;
    #2;
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_sel_pend", 32'(fwd_rt_sel), 32'd1);
    chk("model_lu_stall", 32'(e_stall), 32'd1);
    step();
    chk("lu_stall_done", 32'(stall), 32'd0);
    chk("lu_sel", 32'(fwd_rt_sel), 32'd2);
    chk("lu_data", 32'(fwd_rt_data), 32'h5555);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    step();

    // Two writers of r2: youngest wins
    idset(1, 4'd2, 1, 0, 4'd0, 0, 4'd0, 0); step();
    idset(1, 4'd9, 1, 0, 4'd0, 0, 4'd0, 0); step();
    idset(1, 4'd2, 1, 0, 4'd0, 0, 4'd0, 0); step();
    idset(1, 4'd0, 0, 0, 4'd2, 1, 4'd0, 0);
    res_data = {16'hBBBB, 16'h9999, 16'hAAAA};
    #2;
    chk("prio_sel", 32'(fwd_rs_sel), 32'd1);
    chk("prio_data", 32'(fwd_rs_data), 32'hAAAA);
    chk("model_prio_data", 32'(e_rs.data), 32'hAAAA);
    step();

    // Load-use coinciding with a taken branch: flush wins
    idset(1, 4'd5, 1, 1, 4'd0, 0, 4'd0, 0); step();
    idset(1, 4'd7, 1, 0, 4'd0, 0, 4'd5, 1);
    br_taken = 1'b1;
    #2;
    chk("br_stall", 32'(stall), 32'd0);
    chk("br_flush", 32'(flush), 32'd1);
    step();
    br_taken = 1'b0;
    idset(1, 4'd0, 0, 0, 4'd7, 1, 4'd0, 0);
    #2;
    chk("br_killed_sel", 32'(fwd_rs_sel), 32'd0);
    chk("br_killed_data", 32'(fwd_rs_data), 32'hF00D);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    step();

    // r0 is never forwarded, even from a load
    idset(1, 4'd0, 1, 1, 4'd0, 0, 4'd0, 0); step();
    idset(1, 4'd0, 0, 0, 4'd0, 1, 4'd0, 1);
    #2;
    chk("r0_sel", 32'(fwd_rs_sel), 32'd0);
    chk("r0_data", 32'(fwd_rs_data), 32'hF00D);
    chk("r0_stall", 32'(stall), 32'd0);
    step();

    // Fill every entry with r7 loads, then reset mid-cycle
    idset(1, 4'd7, 1, 1, 4'd0, 0, 4'd0, 0);
    step(); step(); step();
    idset(1, 4'd1, 0, 0, 4'd7, 1, 4'd7, 1);
    #2;
    chk("full_stall", 32'(stall), 32'd1);
    chk("full_sel", 32'(fwd_rs_sel), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_rs_sel", 32'(fwd_rs_sel), 32'd0);
    chk("mid_rst_rt_sel", 32'(fwd_rt_sel), 32'd0);
    chk("mid_rst_rt_data", 32'(fwd_rt_data), 32'hBEEF);
    chk("mid_rst_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("post_rst_sel", 32'(fwd_rs_sel), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    step();

    // Flush counter saturation
    br_taken = 1'b1;
    repeat (65540) step();
    chk("flush_sat", 32'(flush_cnt), 32'h0000FFFF);
    br_taken = 1'b0;
    step();
    chk("flush_sat_hold", 32'(flush_cnt), 32'h0000FFFF);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
